msi_snoop_ctrl: RTL

Bus-side coherence controller for the two-core MSI system. It serves coherence requests that each core's cache controller raises on a miss or a write upgrade. For each request it interrogates the opposite core's msi_cache through its snoop port (search, BOCI, invalidate). It then forwards a MODIFIED line cache-to-cache, writes that line back to memory when needed, or tells the requester to fetch from memory.

---
 rtl/common.sv | 23 ++
 rtl/msi_snoop_ctrl_if.sv | 39 +++
 rtl/msi_snoop_ctrl_rr_arb2.sv | 25 ++
 rtl/msi_snoop_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types and constants for the two-core MSI coherence system.
package common;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } blk_state_t;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StEval,
    StInval,
    StWb,
    StDone
  } snp_state_t;

  localparam int unsigned NUM_CPU = 2;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned LINE_W  = 64;

endpackage

// File: rtl/msi_snoop_ctrl_if.sv
// Request/response, snoop and write-back signals around the snoop controller.
interface msi_snoop_ctrl_if;
  import common::*;

  logic [NUM_CPU-1:0]             req;
  logic [NUM_CPU-1:0]             req_wr;
  logic [NUM_CPU-1:0][ADDR_W-1:0] req_addr;

  logic [NUM_CPU-1:0]             resp_valid;
  logic                           resp_fwd;
  blk_state_t                     resp_state;
  logic [LINE_W-1:0]              resp_data;

  logic [NUM_CPU-1:0]             snp_search;
  logic [ADDR_W-1:0]              snp_boci;
  logic [NUM_CPU-1:0]             snp_inval;
  logic [NUM_CPU-1:0]             snp_found;
  logic [NUM_CPU-1:0][LINE_W-1:0] snp_line;

  logic                           wb_valid;
  logic [ADDR_W-1:0]              wb_addr;
  logic [LINE_W-1:0]              wb_data;
  logic                           wb_ready;

  // Controller side.
  modport slave (
    input  req, req_wr, req_addr, snp_found, snp_line, wb_ready,
    output resp_valid, resp_fwd, resp_state, resp_data,
    output snp_search, snp_boci, snp_inval, wb_valid, wb_addr, wb_data
  );

  // Cores, caches and memory side.
  modport master (
    output req, req_wr, req_addr, snp_found, snp_line, wb_ready,
    input  resp_valid, resp_fwd, resp_state, resp_data,
    input  snp_search, snp_boci, snp_inval, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/msi_snoop_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves away from the core just served.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q;

  assign gnt_valid = |req;
  assign gnt_id    = req[ptr_q] ? ptr_q : ~ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (done) begin
      ptr_q <= ~done_id;
    end
  end

endmodule

// File: rtl/msi_snoop_ctrl.sv
// Bus-side MSI coherence controller: snoops the opposite cache, forwards or writes back.
module msi_snoop_ctrl
  import common::*;
(
  input  logic             clk,
  input  logic             rst_n,
  msi_snoop_ctrl_if.slave  bus
);

  snp_state_t        state_q, state_d;
  logic              gnt_id_q;
  logic              gnt_wr_q;
  logic [ADDR_W-1:0] gnt_addr_q;
  logic              fwd_hit_q;
  logic [LINE_W-1:0] fwd_buf_q;

  logic arb_valid;
  logic arb_id;
  logic done;
  logic snoop_id;

  assign done     = (state_q == StDone);
  assign snoop_id = ~gnt_id_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req),
    .done      (done),
    .done_id   (gnt_id_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant fields latch in IDLE; the snoop result latches on the edge that ends SEARCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_id_q   <= 1'b0;
      gnt_wr_q   <= 1'b0;
      gnt_addr_q <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_buf_q  <= '0;
    end else begin
      if (state_q == StIdle && arb_valid) begin
        gnt_id_q   <= arb_id;
        gnt_wr_q   <= bus.req_wr[arb_id];
        gnt_addr_q <= bus.req_addr[arb_id];
      end
      if (state_q == StSearch) begin
        fwd_hit_q <= bus.snp_found[snoop_id];
        fwd_buf_q <= bus.snp_line[snoop_id];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (arb_valid) state_d = StSearch;
      StSearch: state_d = StEval;
      StEval:   state_d = (fwd_hit_q || gnt_wr_q) ? StInval : StDone;
      StInval:  state_d = (fwd_hit_q && !gnt_wr_q) ? StWb : StDone;
      StWb:     if (bus.wb_ready) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.resp_valid = '0;
    bus.resp_fwd   = 1'b0;
    bus.resp_state = INVALID;
    bus.resp_data  = '0;
    bus.snp_search = '0;
    bus.snp_boci   = '0;
    bus.snp_inval  = '0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    unique case (state_q)
      StSearch: begin
        bus.snp_boci             = gnt_addr_q;
        bus.snp_search[snoop_id] = 1'b1;
      end
      StEval: begin
        bus.snp_boci = gnt_addr_q;
      end
      StInval: begin
        bus.snp_boci            = gnt_addr_q;
        bus.snp_inval[snoop_id] = 1'b1;
      end
      StWb: begin
        bus.wb_valid = 1'b1;
        bus.wb_addr  = gnt_addr_q;
        bus.wb_data  = fwd_buf_q;
      end
      StDone: begin
        bus.resp_valid[gnt_id_q] = 1'b1;
        bus.resp_fwd             = fwd_hit_q;
        bus.resp_state           = gnt_wr_q ? MODIFIED : SHARED;
        bus.resp_data            = fwd_buf_q;
      end
      default: ;
    endcase
  end

endmodule
